dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Load/store controller between the MEM pipeline stage and the data memory.
- Accepts one load or store request per transaction with a valid/ready handshake.
- Drives the data memory's edge-triggered wr/rd strobes, shared tri-state data bus and size mode.
- Checks alignment, sign/zero-extends loads, and returns a one-cycle response to the pipeline.

Parameters:
WIDTH, 32, address and data width in bits.
TIMEOUT_CYC, 15, maximum read-wait cycles before an error is flagged (only used with the optional feature).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  pipeline request present.
req_ready  output  1  controller idle; a request is accepted when req_valid & req_ready.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  0 = word, 1 = halfword, 2 = byte, 3 = illegal.
req_signed  input  1  sign-extend byte/half loads.
req_addr  input  WIDTH  byte address.
req_wdata  input  WIDTH  store data; the low bits are used for half/byte.
resp_valid  output  1  one-cycle pulse; transaction complete.
resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
resp_err  output  1  qualified by resp_valid; misaligned, illegal size, or timeout.
mem_add  output  WIDTH  memory address.
mem_data  inout  WIDTH  shared data bus.
mem_wr  output  1  write strobe; memory acts on its rising edge.
mem_rd  output  1  read strobe; memory drives the bus while it is high.
mem_rd_st  input  1  memory read-status; high once the read data is valid.
mem_mode  output  2  size mode to memory; same encoding as req_size.

Behaviour:
- Reset (rst=1 at a clk edge, also mid-transaction):
  - State goes to IDLE and any in-flight request is discarded; no response is issued.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr=0, mem_rd=0, mem_add=0, mem_mode=0, mem_data=Z.
- States: IDLE, SETUP, STROBE, WAIT, HOLD, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, size, we, signed and wdata.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=3 → DONE with err=1; no strobe is ever raised.
  - Otherwise → SETUP.
- SETUP (1 cycle):
  - mem_add and mem_mode are driven from the latched request.
  - For a store, mem_data is driven with wdata.
  - Strobes stay low → STROBE.
- STROBE (1 cycle):
  - Store: mem_wr=1 → HOLD.
  - Load: mem_rd=1 → WAIT.
- HOLD (store only, 1 cycle): mem_wr=0, data still driven for hold time → DONE.
- WAIT (load only):
  - mem_rd stays 1.
  - On a cycle with mem_rd_st=1, capture mem_data, extend it, drop mem_rd → DONE.
  - Minimum of 1 cycle in WAIT.
- DONE (1 cycle): resp_valid=1, resp_rdata/resp_err valid, req_ready=0 → IDLE.
- req_ready is 0 in every state except IDLE. No request is accepted in the same cycle as resp_valid; back-to-back transactions are separated by IDLE.
- Latency from the accept edge to resp_valid:
  - Store: 4 cycles.
  - Load: 4 cycles plus any extra WAIT cycles.
  - Error: 1 cycle.
- Bus discipline:
  - mem_data is driven only in SETUP/STROBE/HOLD of a store; Z at all other times.
  - The controller never drives mem_data while mem_rd=1.
  - mem_add/mem_mode are held stable from SETUP through the end of the strobe phase.
- Load extension, applied to memory data that arrives zero-extended:
  - Byte: bit 7 is replicated if signed, else zeros.
  - Half: bit 15 is replicated if signed, else zeros.
  - Word: passed through unchanged.
- Byte ordering is handled by the memory; the controller does no lane swapping.

Optional Feature:
DMEM_CTRL_TIMEOUT_EN
- Defined: a 4-bit or wider counter clears on entry to WAIT and increments each WAIT cycle without mem_rd_st. When the count reaches TIMEOUT_CYC, mem_rd drops and the FSM → DONE with resp_err=1 and resp_rdata=0.
- Undefined: no counter; WAIT lasts indefinitely until mem_rd_st.

Decomposition:
- Shared package: size/mode encodings (MODE_WORD=0, MODE_HALF=1, MODE_BYTE=2), FSM state encoding, and the WIDTH default alongside the existing global width define.
- One sub-module, dmem_ld_ext: purely combinational load extender (inputs data, size, signed; output extended word); reused by any future cache path.

Test Plan:
- Store word 0xDEADBEEF at addr 4, then load word at addr 4 → store resp at +4 cycles with err=0; load resp_rdata=0xDEADBEEF; mem_wr high exactly 1 cycle.
- Store byte 0x80 at addr 5; load byte at addr 5 with signed=1 → 0xFFFFFF80; with signed=0 → 0x00000080.
- Load half at addr 3 and word at addr 2 → resp_valid 1 cycle after accept with err=1, rdata=0; mem_rd/mem_wr never rise.
- Hold req_valid high with three queued requests → req_ready low from accept until the cycle after resp_valid; exactly three responses, in order; mem_data Z whenever mem_rd=1.
- Assert rst during WAIT of a load → next cycle IDLE, mem_rd=0, bus Z, no resp_valid; the following request completes normally.
- With DMEM_CTRL_TIMEOUT_EN and a memory stub that never raises mem_rd_st → resp_err=1 after TIMEOUT_CYC=15 WAIT cycles; without the macro, resp_valid remains 0 for 100 cycles.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory load/store controller.
// DMEM_WIDTH is the legacy global width define; DMEM_WIDTH_DEF mirrors it.
`ifndef DMEM_WIDTH
`define DMEM_WIDTH 32
`endif

package dmem_ctrl_pkg;

  localparam int unsigned DMEM_WIDTH_DEF = `DMEM_WIDTH;

  typedef enum logic [1:0] {
    MODE_WORD = 2'd0,
    MODE_HALF = 2'd1,
    MODE_BYTE = 2'd2,
    MODE_ILL  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // True when the access can never reach memory: illegal size or misaligned.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      MODE_WORD: return lsb != 2'b00;
      MODE_HALF: return lsb[0];
      MODE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ld_ext.sv
// Combinational load extender: sign/zero-extends byte and half loads that
// arrive zero-extended from memory; words pass through.
module dmem_ld_ext
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DMEM_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       size,
  input  logic             is_signed,
  output logic [WIDTH-1:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      MODE_HALF: ext = {{(WIDTH-16){is_signed & data[15]}}, data[15:0]};
      MODE_BYTE: ext = {{(WIDTH-8){is_signed & data[7]}}, data[7:0]};
      default:   ext = data;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller between the MEM stage and the data memory.
// Optional read timeout: define DMEM_CTRL_TIMEOUT_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = DMEM_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_add,
  inout  wire  [WIDTH-1:0] mem_data,
  output logic             mem_wr,
  output logic             mem_rd,
  input  logic             mem_rd_st,
  output logic [1:0]       mem_mode
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  state_e           state, state_nx;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, ext_data;
  logic [1:0]       size_q;
  logic             we_q, sgn_q, err_q;
  logic             accept, bad_req, wait_tmo, phase_active, bus_drive;

  assign accept  = req_valid && (state == ST_IDLE);
  assign bad_req = bad_access(req_size, req_addr[1:0]);

  dmem_ld_ext #(.WIDTH(WIDTH)) u_ld_ext (
    .data      (mem_data),
    .size      (size_q),
    .is_signed (sgn_q),
    .ext       (ext_data)
  );

`ifdef DMEM_CTRL_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;
  logic [CW-1:0] tmo_cnt;

  // Counts WAIT cycles without read-status; cleared on the way into WAIT.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state == ST_STROBE)
      tmo_cnt <= '0;
    else if (state == ST_WAIT && !mem_rd_st)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign wait_tmo = (state == ST_WAIT) && !mem_rd_st && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign wait_tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nx = bad_req ? ST_DONE : ST_SETUP;
      ST_SETUP:  state_nx = ST_STROBE;
      ST_STROBE: state_nx = we_q ? ST_HOLD : ST_WAIT;
      ST_HOLD:   state_nx = ST_DONE;
      ST_WAIT:   if (mem_rd_st || wait_tmo) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      // rdata clears per request so stores and errors respond with zero.
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        sgn_q   <= req_signed;
        err_q   <= bad_req;
        rdata_q <= '0;
      end
      if (state == ST_WAIT) begin
        if (mem_rd_st)
          rdata_q <= ext_data;
        else if (wait_tmo)
          err_q <= 1'b1;
      end
    end
  end

  assign phase_active = (state == ST_SETUP) || (state == ST_STROBE) ||
                        (state == ST_WAIT)  || (state == ST_HOLD);
  assign bus_drive    = we_q && ((state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD));

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
  assign mem_add    = phase_active ? addr_q : '0;
  assign mem_mode   = phase_active ? size_q : '0;
  assign mem_wr     = (state == ST_STROBE) && we_q;
  assign mem_rd     = ((state == ST_STROBE) && !we_q) || (state == ST_WAIT);
  assign mem_data   = bus_drive ? wdata_q : 'z;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-array memory stub, transaction-level reference
// model checked every cycle, directed and randomized transactions.
module tb_dmem_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic [W-1:0]  req_addr = '0, req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_wr, mem_rd, mem_rd_st;
  logic [W-1:0]  resp_rdata, mem_add;
  logic [1:0]    mem_mode;
  wire  [W-1:0]  mem_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.WIDTH(W), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_add    (mem_add),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_rd_st  (mem_rd_st),
    .mem_mode   (mem_mode)
  );

  function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 2;
      2'd2:    return 1;
      default: return 0;
    endcase
  endfunction

  // ---------------- memory stub (64 bytes, little-endian, zero-extended reads)
  logic [7:0]   smem [64];
  logic [W-1:0] stub_rd;
  int unsigned  stub_delay = 0;
  int unsigned  rd_cnt = 0;

  initial for (int i = 0; i < 64; i++) smem[i] = 8'h00;

  always_comb begin
    stub_rd = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(nbytes(mem_mode))) stub_rd[8*i +: 8] = smem[6'(mem_add[5:0] + 6'(i))];
  end

  always @(posedge mem_wr)
    for (int i = 0; i < 4; i++)
      if (i < int'(nbytes(mem_mode))) smem[6'(mem_add[5:0] + 6'(i))] = mem_data[8*i +: 8];

  always @(posedge clk) rd_cnt <= mem_rd ? rd_cnt + 1 : 0;

  assign mem_rd_st = mem_rd && (rd_cnt >= stub_delay + 1);
  assign mem_data  = mem_rd ? stub_rd : 'z;

  // ---------------- reference model: one transaction at a time on a timeline
  logic [7:0]   mmem [64];
  bit           m_busy = 0, m_we, m_sgn, m_err;
  logic [1:0]   m_size;
  logic [W-1:0] m_addr, m_wdata, m_rdata;
  int unsigned  m_off, m_resp;
  bit           chk_en = 0;

  initial for (int i = 0; i < 64; i++) mmem[i] = 8'h00;

  function automatic logic [W-1:0] model_load();
    longint v = 0;
    for (int i = 0; i < int'(nbytes(m_size)); i++)
      v += longint'(mmem[6'(m_addr[5:0] + 6'(i))]) << (8*i);
    if (m_sgn && m_size == 2'd1 && v >= 32768) v -= 65536;
    if (m_sgn && m_size == 2'd2 && v >= 128)   v -= 256;
    return W'(v);
  endfunction

  always @(negedge clk) if (chk_en) begin
    bit exp_rv, exp_wr, exp_rd;
    exp_rv = m_busy && m_resp != 0 && m_off == m_resp;
    exp_wr = m_busy && m_we && !m_err && m_off == 2;
    exp_rd = m_busy && !m_we && !m_err && m_off >= 2 && !exp_rv;
    check("req_ready", W'(req_ready), W'(!m_busy));
    check("resp_valid", W'(resp_valid), W'(exp_rv));
    check("resp_err", W'(resp_err), W'(exp_rv && m_err));
    check("resp_rdata", resp_rdata, exp_rv ? m_rdata : '0);
    check("mem_wr", W'(mem_wr), W'(exp_wr));
    check("mem_rd", W'(mem_rd), W'(exp_rd));
    if (m_busy && !m_err && !exp_rv) begin
      check("mem_add", mem_add, m_addr);
      check("mem_mode", W'(mem_mode), W'(m_size));
      if (m_we) check("store bus", mem_data, m_wdata);
    end
    if (mem_rd) check("load bus", mem_data, stub_rd);

    // advance to the next cycle
    if (rst) m_busy = 0;
    else if (m_busy) begin
      if (exp_rv) m_busy = 0;
      else begin
        if (!m_we && !m_err && m_resp == 0 && m_off >= 3) begin
          if (mem_rd_st) begin
            m_resp  = m_off + 1;
            m_rdata = model_load();
          end
`ifdef DMEM_CTRL_TIMEOUT_EN
          else if (m_off - 2 >= TMO) begin
            m_resp  = m_off + 1;
            m_err   = 1;
            m_rdata = '0;
          end
`endif
        end
        m_off++;
      end
    end else if (req_valid) begin
      m_busy  = 1;
      m_off   = 1;
      m_we    = req_we;
      m_sgn   = req_signed;
      m_size  = req_size;
      m_addr  = req_addr;
      m_wdata = req_wdata;
      m_rdata = '0;
      m_err   = (req_size == 2'd3) || (req_size == 2'd1 && req_addr % 2 != 0) ||
                (req_size == 2'd0 && req_addr % 4 != 0);
      m_resp  = m_err ? 1 : (m_we ? 4 : 0);
      if (m_we && !m_err)
        for (int i = 0; i < int'(nbytes(m_size)); i++)
          mmem[6'(m_addr[5:0] + 6'(i))] = 8'(m_wdata >> (8*i));
    end
  end

  // ---------------- stimulus
  task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [W-1:0] addr, input logic [W-1:0] wd,
                       input int unsigned dly, input bit hold);
    bit acc = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd; stub_delay = dly;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
    end
    check("accept", W'(acc), W'(1));
    @(posedge clk);
    if (!hold) begin
      #1 req_valid = 0;
    end
  endtask

  task automatic wait_resp(input int unsigned budget, output bit got,
                           output logic [W-1:0] rd, output bit er, output int unsigned lat);
    got = 0; rd = '0; er = 0; lat = 0;
    for (int unsigned i = 1; i <= budget && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1; rd = resp_rdata; er = resp_err; lat = i;
      end
    end
  endtask

  task automatic xact(input string nm, input bit we, input logic [1:0] size, input bit sgn,
                      input logic [W-1:0] addr, input logic [W-1:0] wd, input int unsigned dly,
                      input bit hold, input bit x_err, input logic [W-1:0] x_rd,
                      input int unsigned x_lat);
    bit got, er;
    logic [W-1:0] rd;
    int unsigned lat;
    issue(we, size, sgn, addr, wd, dly, hold);
    wait_resp(64, got, rd, er, lat);
    check({nm, " got"}, W'(got), W'(1));
    check({nm, " err"}, W'(er), W'(x_err));
    check({nm, " rdata"}, rd, x_rd);
    check({nm, " lat"}, W'(lat), W'(x_lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, er;
    logic [W-1:0] rd;
    int unsigned lat;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", W'(req_ready), W'(1));
    check("rst resp_valid", W'(resp_valid), W'(0));
    check("rst mem_wr", W'(mem_wr), W'(0));
    check("rst mem_rd", W'(mem_rd), W'(0));
    check("rst mem_add", mem_add, '0);
    check("rst mem_mode", W'(mem_mode), W'(0));
    check("rst resp_rdata", resp_rdata, '0);
    chk_en = 1;
    @(posedge clk); #1 rst = 0;

    xact("st w4",   1, 2'd0, 0, 32'd4, 32'hDEADBEEF, 0, 0, 0, 32'h0,        4);
    xact("ld w4",   0, 2'd0, 0, 32'd4, 32'h0,        0, 0, 0, 32'hDEADBEEF, 4);
    xact("ld w4 d2",0, 2'd0, 0, 32'd4, 32'h0,        2, 0, 0, 32'hDEADBEEF, 6);
    xact("st b5",   1, 2'd2, 0, 32'd5, 32'h12345680, 0, 0, 0, 32'h0,        4);
    xact("ld sb5",  0, 2'd2, 1, 32'd5, 32'h0,        1, 0, 0, 32'hFFFFFF80, 5);
    xact("ld ub5",  0, 2'd2, 0, 32'd5, 32'h0,        0, 0, 0, 32'h00000080, 4);
    xact("ld sh4",  0, 2'd1, 1, 32'd4, 32'h0,        0, 0, 0, 32'hFFFF80EF, 4);
    xact("ld h3",   0, 2'd1, 0, 32'd3, 32'h0,        0, 0, 1, 32'h0,        1);
    xact("ld w2",   0, 2'd0, 0, 32'd2, 32'h0,        0, 0, 1, 32'h0,        1);
    xact("st sz3",  1, 2'd3, 0, 32'd0, 32'h55,       0, 0, 1, 32'h0,        1);

    // three queued requests with req_valid held high
    xact("q st w8", 1, 2'd0, 0, 32'd8,  32'h11223344, 0, 1, 0, 32'h0,    4);
    xact("q ld h10",0, 2'd1, 0, 32'd10, 32'h0,        0, 1, 0, 32'h1122, 4);
    xact("q ld b9", 0, 2'd2, 1, 32'd9,  32'h0,        0, 0, 0, 32'h33,   4);

    // reset while a load sits in WAIT
    issue(0, 2'd0, 0, 32'd8, 32'h0, 1000, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rstw mem_rd", W'(mem_rd), W'(0));
    check("rstw resp_valid", W'(resp_valid), W'(0));
    check("rstw req_ready", W'(req_ready), W'(1));
    xact("post rst ld", 0, 2'd0, 0, 32'd8, 32'h0, 0, 0, 0, 32'h11223344, 4);

    // memory that never signals read-status
    issue(0, 2'd0, 0, 32'd0, 32'h0, 1000, 0);
`ifdef DMEM_CTRL_TIMEOUT_EN
    wait_resp(40, got, rd, er, lat);
    check("tmo got", W'(got), W'(1));
    check("tmo err", W'(er), W'(1));
    check("tmo rdata", rd, '0);
    check("tmo lat", W'(lat), W'(TMO + 3));
`else
    wait_resp(100, got, rd, er, lat);
    check("no tmo resp", W'(got), W'(0));
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
`endif

    for (int k = 0; k < 60; k++) begin
      bit we, sgn, hold;
      logic [1:0] sz;
      logic [W-1:0] ad;
      int unsigned dly;
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad  = W'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 4) != 0)
        ad = ad & ((sz == 2'd0) ? ~W'(3) : (sz == 2'd1) ? ~W'(1) : ~W'(0));
      dly  = ($urandom_range(0, 5) == 0) ? 6 : $urandom_range(0, 3);
      hold = (k != 59) && ($urandom_range(0, 1) == 1);
      issue(we, sz, sgn, ad, W'($urandom), dly, hold);
      wait_resp(64, got, rd, er, lat);
      check("rand got", W'(got), W'(1));
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
